perf_sampler: RTL and testbench

PERF_SAMPLER -- requirements
Module: perf_sampler

---
 rtl/perf_sampler_if.sv | 33 +++
 rtl/perf_sampler.sv | 226 ++++++++++++++++++++++
 tb/tb_perf_sampler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_sampler_if.sv
// Bus bundle for perf_sampler: config request, PMU command/read port and snapshot stream.
interface perf_sampler_if;
  logic        sample_enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_counter;
  logic [15:0] cfg_event;
  logic        cfg_enable;
  logic        perf_write_en;
  logic [31:0] perf_write_data;
  logic        perf_read_en;
  logic [31:0] perf_read_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  sample_index;
  logic [31:0] sample_value;
  logic        sample_last;
  logic [15:0] overrun_count;

  modport slave (
    input  sample_enable, cfg_valid, cfg_counter, cfg_event, cfg_enable,
           perf_read_data, sample_ready,
    output cfg_ready, perf_write_en, perf_write_data, perf_read_en,
           sample_valid, sample_index, sample_value, sample_last, overrun_count
  );

  modport master (
    output sample_enable, cfg_valid, cfg_counter, cfg_event, cfg_enable,
           perf_read_data, sample_ready,
    input  cfg_ready, perf_write_en, perf_write_data, perf_read_en,
           sample_valid, sample_index, sample_value, sample_last, overrun_count
  );
endinterface

// File: rtl/perf_sampler.sv
// Periodic PMU sampler: programs counters via command words and sweeps them into a snapshot stream.
// Optional feature macro PERF_SAMPLER_OVERRUN_EN counts triggers dropped while a sweep is pending or running.
module perf_sampler #(
  parameter int unsigned NUM_COUNTERS  = 4,
  parameter int unsigned SAMPLE_PERIOD = 1024
) (
  input  logic          clk,
  input  logic          reset,
  perf_sampler_if.slave bus
);
  localparam int unsigned     TW         = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]      LAST_IDX   = 8'(NUM_COUNTERS - 1);

  typedef enum logic [2:0] {
    IDLE, CFG_SEL, CFG_EVT, CFG_EN, SMP_SEL, SMP_RD, SMP_CAP, SMP_OUT
  } state_t;

  function automatic logic [31:0] cmd_select(input logic [7:0] idx);
    return {2'b00, 22'd0, idx};
  endfunction

  function automatic logic [31:0] cmd_enable(input logic en);
    return {2'b01, 29'd0, en};
  endfunction

  function automatic logic [31:0] cmd_event(input logic [15:0] mask);
    return {2'b10, 14'd0, mask};
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [7:0]    index_q, index_d;
  logic [7:0]    cfg_counter_q, cfg_counter_d;
  logic [15:0]   cfg_event_q, cfg_event_d;
  logic          cfg_enable_q, cfg_enable_d;
  logic [15:0]   overrun_q, overrun_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          rd_en_q, rd_en_d;
  logic          valid_q, valid_d;
  logic [31:0]   value_q, value_d;
  logic          last_q, last_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          trigger_s;
  logic          smp_busy_s;
`ifdef PERF_SAMPLER_OVERRUN_EN
  logic          drop_s;
`endif

  // Free-running period timer; the trigger fires on the wrap cycle
  always_comb begin
    trigger_s = 1'b0;
    timer_d   = '0;
    if (bus.sample_enable) begin
      if (timer_q == TIMER_LAST) begin
        trigger_s = 1'b1;
        timer_d   = '0;
      end else begin
        trigger_s = 1'b0;
        timer_d   = timer_q + TW'(1);
      end
    end else begin
      trigger_s = 1'b0;
      timer_d   = '0;
    end
  end

  assign smp_busy_s = (state_q == SMP_SEL) || (state_q == SMP_RD) ||
                      (state_q == SMP_CAP) || (state_q == SMP_OUT);

`ifdef PERF_SAMPLER_OVERRUN_EN
  assign drop_s = trigger_s && (pending_q || smp_busy_s);
`endif

  // Overrun counter next state
  always_comb begin
`ifdef PERF_SAMPLER_OVERRUN_EN
    if (drop_s && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end else begin
      overrun_d = overrun_q;
    end
`else
    overrun_d = 16'd0;
`endif
  end

  // FSM next state, sweep index, pending flag and config capture
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    pending_d     = pending_q;
    cfg_counter_d = cfg_counter_q;
    cfg_event_d   = cfg_event_q;
    cfg_enable_d  = cfg_enable_q;
    value_d       = value_q;
    if (trigger_s && !pending_q && !smp_busy_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    case (state_q)
      IDLE: begin
        // Config requests win over a pending sweep
        if (bus.cfg_valid) begin
          cfg_counter_d = bus.cfg_counter;
          cfg_event_d   = bus.cfg_event;
          cfg_enable_d  = bus.cfg_enable;
          state_d       = CFG_SEL;
        end else if (pending_q) begin
          pending_d = 1'b0;
          index_d   = 8'd0;
          state_d   = SMP_SEL;
        end else begin
          state_d = IDLE;
        end
      end
      CFG_SEL: state_d = CFG_EVT;
      CFG_EVT: state_d = CFG_EN;
      CFG_EN:  state_d = IDLE;
      SMP_SEL: state_d = SMP_RD;
      SMP_RD:  state_d = SMP_CAP;
      SMP_CAP: begin
        value_d = bus.perf_read_data;
        state_d = SMP_OUT;
      end
      SMP_OUT: begin
        if (bus.sample_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            index_d = index_q + 8'd1;
            state_d = SMP_SEL;
          end
        end else begin
          state_d = SMP_OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop aligned with its state
  always_comb begin
    wr_en_d     = 1'b0;
    wr_data_d   = 32'd0;
    rd_en_d     = 1'b0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    cfg_ready_d = 1'b0;
    case (state_d)
      IDLE:    cfg_ready_d = 1'b1;
      CFG_SEL: begin
        wr_en_d   = 1'b1;
        wr_data_d = cmd_select(cfg_counter_d);
      end
      CFG_EVT: begin
        wr_en_d   = 1'b1;
        wr_data_d = cmd_event(cfg_event_d);
      end
      CFG_EN: begin
        wr_en_d   = 1'b1;
        wr_data_d = cmd_enable(cfg_enable_d);
      end
      SMP_SEL: begin
        wr_en_d   = 1'b1;
        wr_data_d = cmd_select(index_d);
      end
      SMP_RD:  rd_en_d = 1'b1;
      SMP_OUT: begin
        valid_d = 1'b1;
        last_d  = (index_d == LAST_IDX);
      end
      default: cfg_ready_d = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      index_q       <= 8'd0;
      cfg_counter_q <= 8'd0;
      cfg_event_q   <= 16'd0;
      cfg_enable_q  <= 1'b0;
      overrun_q     <= 16'd0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= 32'd0;
      rd_en_q       <= 1'b0;
      valid_q       <= 1'b0;
      value_q       <= 32'd0;
      last_q        <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      index_q       <= index_d;
      cfg_counter_q <= cfg_counter_d;
      cfg_event_q   <= cfg_event_d;
      cfg_enable_q  <= cfg_enable_d;
      overrun_q     <= overrun_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      rd_en_q       <= rd_en_d;
      valid_q       <= valid_d;
      value_q       <= value_d;
      last_q        <= last_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

  assign bus.cfg_ready       = cfg_ready_q;
  assign bus.perf_write_en   = wr_en_q;
  assign bus.perf_write_data = wr_data_q;
  assign bus.perf_read_en    = rd_en_q;
  assign bus.sample_valid    = valid_q;
  assign bus.sample_index    = index_q;
  assign bus.sample_value    = value_q;
  assign bus.sample_last     = last_q;
  assign bus.overrun_count   = overrun_q;
endmodule

// File: tb/tb_perf_sampler.sv
// Self-checking bench for perf_sampler: config vector table, scoreboarded PMU writes and snapshots,
// plus hand-written stall, coincidence, overrun and mid-sweep reset sequences.
module tb_perf_sampler;
  localparam int NC = 4;
  localparam int SP = 16;

  logic clk;
  logic reset;

  perf_sampler_if bus();

  perf_sampler #(.NUM_COUNTERS(NC), .SAMPLE_PERIOD(SP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PMU model: remembers the selected counter and returns 100+index a cycle after a read
  logic [7:0]  pmu_sel = 8'd0;
  logic [31:0] pmu_rd  = 32'd0;
  always @(posedge clk) begin
    if (bus.perf_write_en && bus.perf_write_data[31:30] == 2'b00) pmu_sel <= bus.perf_write_data[7:0];
    if (bus.perf_read_en) pmu_rd <= 32'd100 + {24'd0, pmu_sel};
  end
  assign bus.perf_read_data = pmu_rd;

  typedef struct packed {
    logic [7:0]  counter;
    logic [15:0] evt;
    logic        en;
    logic [31:0] w_sel;
    logic [31:0] w_evt;
    logic [31:0] w_en;
  } cfg_vec_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] val;
    logic        last;
  } smp_t;

  cfg_vec_t    vecs [4];
  smp_t        exp_smp [$];
  logic [31:0] exp_wr [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel0_cyc = 0;
  int last_cyc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NC; i++) begin
      exp_wr.push_back(32'(i));
      exp_smp.push_back('{idx: 8'(i), val: 32'd100 + 32'(i), last: (i == NC - 1)});
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_smp.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (exp_wr.size() != 0 || exp_smp.size() != 0)
      fail("drain_timeout", $sformatf("writes left %0d, samples left %0d", exp_wr.size(), exp_smp.size()));
  endtask

  task automatic wait_write(input int budget);
    int n;
    n = 0;
    while (!bus.perf_write_en && n < budget) begin
      step();
      n++;
    end
    if (!bus.perf_write_en) fail("trigger_timeout", "no sweep select write seen");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write_en"},   32'(bus.perf_write_en), 32'd0);
    chk({tag, "_write_data"}, bus.perf_write_data, 32'd0);
    chk({tag, "_read_en"},    32'(bus.perf_read_en), 32'd0);
    chk({tag, "_valid"},      32'(bus.sample_valid), 32'd0);
    chk({tag, "_value"},      bus.sample_value, 32'd0);
    chk({tag, "_index"},      32'(bus.sample_index), 32'd0);
    chk({tag, "_last"},       32'(bus.sample_last), 32'd0);
    chk({tag, "_overrun"},    32'(bus.overrun_count), 32'd0);
  endtask

  // Scoreboard side: compare PMU writes and accepted snapshots against queued expectations
  task automatic monitor();
    logic [31:0] w;
    smp_t        s;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.perf_write_en || bus.perf_read_en)
        chk("strobe_exclusive", 32'(bus.perf_write_en & bus.perf_read_en), 32'd0);
      if (bus.perf_write_en) begin
        if (exp_wr.size() == 0) begin
          fail("unexpected_write", $sformatf("got 0x%0h with none expected", bus.perf_write_data));
        end else begin
          w = exp_wr.pop_front();
          chk("pmu_write", bus.perf_write_data, w);
          if (bus.perf_write_data == 32'd0) sel0_cyc = cyc;
        end
      end
      if (bus.sample_valid && bus.sample_ready) begin
        if (exp_smp.size() == 0) begin
          fail("unexpected_sample", $sformatf("index %0d value %0d", bus.sample_index, bus.sample_value));
        end else begin
          s = exp_smp.pop_front();
          chk("sample_index", 32'(bus.sample_index), 32'(s.idx));
          chk("sample_value", bus.sample_value, s.val);
          chk("sample_last",  32'(bus.sample_last), 32'(s.last));
          if (bus.sample_last) last_cyc = cyc;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int bad;
    int strobes;
    logic [15:0] exp_ovr;

    vecs[0] = '{8'd2,   16'h0004, 1'b1, 32'h0000_0002, 32'h8000_0004, 32'h4000_0001};
    vecs[1] = '{8'd0,   16'hFFFF, 1'b0, 32'h0000_0000, 32'h8000_FFFF, 32'h4000_0000};
    vecs[2] = '{8'd255, 16'h8001, 1'b1, 32'h0000_00FF, 32'h8000_8001, 32'h4000_0001};
    vecs[3] = '{8'd7,   16'h1234, 1'b0, 32'h0000_0007, 32'h8000_1234, 32'h4000_0000};

    reset             = 1'b0;
    bus.sample_enable = 1'b0;
    bus.cfg_valid     = 1'b0;
    bus.cfg_counter   = 8'd0;
    bus.cfg_event     = 16'd0;
    bus.cfg_enable    = 1'b0;
    bus.sample_ready  = 1'b1;
    fork
      monitor();
    join_none

    #12;
    check_reset_outputs("reset");
    step();
    reset = 1'b1;
    step();
    chk("reset_cfg_ready", 32'(bus.cfg_ready), 32'd1);

    // Config vectors
    for (int v = 0; v < 4; v++) begin
      exp_wr.push_back(vecs[v].w_sel);
      exp_wr.push_back(vecs[v].w_evt);
      exp_wr.push_back(vecs[v].w_en);
      bus.cfg_counter = vecs[v].counter;
      bus.cfg_event   = vecs[v].evt;
      bus.cfg_enable  = vecs[v].en;
      bus.cfg_valid   = 1'b1;
      step();
      bus.cfg_valid = 1'b0;
      lo = 0;
      for (int c = 0; c < 3; c++) begin
        if (!bus.cfg_ready) lo++;
        step();
      end
      chk("cfg_ready_low_cycles", 32'(lo), 32'd3);
      chk("cfg_ready_back", 32'(bus.cfg_ready), 32'd1);
    end
    chk("cfg_writes_drained", 32'(exp_wr.size()), 32'd0);

    // Full sweep with ready tied high; enable dropped mid-sweep must not abort it
    push_sweep();
    bus.sample_enable = 1'b1;
    wait_write(40);
    bus.sample_enable = 1'b0;
    wait_drain(40);
    chk("sweep_cycles", 32'(last_cyc - sel0_cyc), 32'd15);

    // Back-pressure at index 1 for 10 cycles
    push_sweep();
    bus.sample_enable = 1'b1;
    lo = 0;
    while (!(bus.sample_valid && bus.sample_index == 8'd1) && lo < 80) begin
      step();
      lo++;
    end
    bus.sample_ready  = 1'b0;
    bus.sample_enable = 1'b0;
    chk("stall_reached_index1", 32'(bus.sample_valid && bus.sample_index == 8'd1), 32'd1);
    bad = 0;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      if (!bus.sample_valid || bus.sample_index != 8'd1 || bus.sample_value != 32'd101 || bus.sample_last) bad++;
      if (bus.perf_write_en || bus.perf_read_en) strobes++;
      step();
    end
    chk("stall_hold", 32'(bad), 32'd0);
    chk("stall_no_strobe", 32'(strobes), 32'd0);
    bus.sample_ready = 1'b1;
    wait_drain(40);

    // Trigger coincident with a config request: config runs first, then the sweep
    bus.sample_enable = 1'b1;
    for (int c = 0; c < SP - 1; c++) step();
    exp_wr.push_back(32'h0000_0002);
    exp_wr.push_back(32'h8000_0004);
    exp_wr.push_back(32'h4000_0001);
    push_sweep();
    bus.cfg_counter = 8'd2;
    bus.cfg_event   = 16'h0004;
    bus.cfg_enable  = 1'b1;
    bus.cfg_valid   = 1'b1;
    step();
    bus.cfg_valid     = 1'b0;
    bus.sample_enable = 1'b0;
    chk("coincide_cfg_accepted", 32'(bus.cfg_ready), 32'd0);
    wait_drain(60);

    // Triggers dropped while the sweep is stuck on back-pressure
    push_sweep();
    bus.sample_ready  = 1'b0;
    bus.sample_enable = 1'b1;
    for (int c = 0; c < 70; c++) step();
    bus.sample_enable = 1'b0;
`ifdef PERF_SAMPLER_OVERRUN_EN
    exp_ovr = 16'd3;
`else
    exp_ovr = 16'd0;
`endif
    chk("overrun_count", 32'(bus.overrun_count), 32'(exp_ovr));
    bus.sample_ready = 1'b1;
    wait_drain(40);

    // Reset asserted while a read strobe is out
    push_sweep();
    bus.sample_enable = 1'b1;
    lo = 0;
    while (!bus.perf_read_en && lo < 40) begin
      step();
      lo++;
    end
    chk("reached_smp_rd", 32'(bus.perf_read_en), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midsweep_reset");
    exp_wr.delete();
    exp_smp.delete();
    bus.sample_enable = 1'b0;
    step();
    step();
    reset = 1'b1;
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.perf_write_en || bus.perf_read_en) strobes++;
      step();
    end
    chk("post_reset_no_strobe", 32'(strobes), 32'd0);

    // Recovery sweep after reset
    push_sweep();
    bus.sample_enable = 1'b1;
    wait_write(40);
    bus.sample_enable = 1'b0;
    wait_drain(40);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
